dmem_lane_sched: RTL and testbench
==================================

Name: dmem_lane_sched

Overview:
- Shares one single-port, 1-cycle-read-latency data memory between VLIW memory lanes 3 and 4.
- Posted stores go into an internal store queue that drains to memory whenever the port is idle.
- Loads get port priority, and are ordered against queued stores by stalling until the conflicting stores have drained.
- Sits between the M stage and the data memory; raises `stall` to freeze the front of the pipeline.

Parameters:
- DEPTH, 8, store-queue entries; power of 2, minimum 2.
- PTR_W, 3, log2(DEPTH).

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- v3  in  1  lane-3 memory request valid
- we3  in  1  lane-3 store (1) or load (0)
- addr3  in  32  lane-3 address
- wdata3  in  32  lane-3 store data
- v4, we4, addr4, wdata4  in  1/1/32/32  lane-4 equivalents
- stall  out  1  bundle not accepted this cycle; requests must be held unchanged next cycle
- rdata3  out  32  lane-3 load data, valid the cycle after bundle acceptance
- rdata4  out  32  lane-4 load data, valid the cycle after bundle acceptance
- mem_en  out  1  memory port enable
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, 1 cycle after a read with mem_en=1 and mem_we=0
- sq_empty  out  1  store queue empty; used by halt/flush logic

Behaviour:
- Reset (rstn=0 at a clk edge): queue pointers and count cleared, pending stores discarded, FSM to S_RUN, hold3 register cleared to 0.
- While rstn=0: stall=0, mem_en=0, mem_we=0, sq_empty=1.
- stall and the mem_* outputs are combinational from current requests and state.
- Bundle acceptance is atomic: a bundle is accepted in the cycle where stall=0. Stores enqueue only at acceptance; lane 3 enqueues before lane 4.
- Port budget: one memory access per cycle. Priority is load, then queue drain.
- hz3: lane 3 is a load and its addr3 equals the address of any valid queue entry.
- hz4: lane 4 is a load and either addr4 matches a valid queue entry, or lane 3 is a store with addr3==addr4.
- A lane-4 store to the same address as a lane-3 load is not a hazard: the load reads the old value.
- full: number of stores in the bundle > DEPTH - count, using count from before this cycle's dequeue (conservative).
- S_RUN, case hz3|hz4|full: stall=1, no load issued, port drains the queue head if non-empty.
- S_RUN, case two loads and no hazard: issue lane-3 read, stall=1, go to S_LOAD4.
- S_RUN, case otherwise: stall=0. Issue the single load if any, else drain the head. Enqueue the bundle's stores.
- S_LOAD4: issue lane-4 read, stall=0, capture mem_rdata into hold3, return to S_RUN.
- rdata3 = hold3 if the previous cycle was S_LOAD4, else mem_rdata. rdata4 = mem_rdata.
- rdata values are don't-care when the lane did not load.
- Drain: mem_en=1, mem_we=1, address and data from head. Head pops in the same cycle.
- Simultaneous enqueue of up to 2 and dequeue of 1 updates count by the net amount. Pointers wrap modulo DEPTH.
- Match search covers exactly the count valid entries, including wrapped ones. Invalid entries never match.
- A popped entry no longer blocks: a hazard clears the cycle after its last matching store drains.
- v3=v4=0: stall=0; drain if non-empty.

Decomposition:
- Shared header: FSM encodings S_RUN and S_LOAD4; default DEPTH.
- Sub-module `store_queue`: circular buffer with 2 write ports and 1 pop port.
  - Outputs: head, count, empty.
  - Outputs two address-match lines (for addr3 and addr4) over valid entries.
- Scheduler FSM and muxing stay in dmem_lane_sched.

Test Plan:
- Two stores: lane3 store 0x10←0xAA and lane4 store 0x14←0xBB, no further requests.
  - stall=0; next two cycles write 0x10 then 0x14; sq_empty=1 after.
- Two loads: after reset with memory preloaded (0x20=5, 0x24=7), lane3 load 0x20 and lane4 load 0x24.
  - stall=1 for one cycle, then 0; in the cycle after acceptance rdata3=5 and rdata4=7.
- RAW hazard against the queue: queue holds store 0x30←9; lane3 load 0x30.
  - stall=1 until the drain completes, then accepted; rdata3=9.
- In-bundle hazard: lane3 store 0x40←3 and lane4 load 0x40.
  - Stalls only until the queued 0x40 drains; rdata4=3.
  - A lane4 store to 0x40 plus a lane3 load of 0x40 does not stall and returns the old value.
- Full queue: fill 8 stores to distinct addresses while lane-3 loads occupy the port, then present a two-store bundle.
  - stall=1 until count≤6; no entry lost, all 10 addresses written in order.
- Reset mid-drain: assert rstn=0 with 5 entries queued.
  - Next cycle sq_empty=1 and mem_we=0; no further writes after reset release.

Source files
------------

// File: rtl/dmem_lane_sched_pkg.sv
// Shared definitions for the lane-3/lane-4 data-memory scheduler.
package dmem_lane_sched_pkg;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_LOAD4 = 1'b1
    } state_e;

    localparam int DEPTH_DEF = 8;

endpackage

// File: rtl/dmem_lane_sched_store_queue.sv
// Circular store queue: two ordered write ports, one pop port, and address
// match lines computed over the currently valid entries only.
module store_queue
    import dmem_lane_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push0_i,
    input  logic [31:0]      push0_addr_i,
    input  logic [31:0]      push0_data_i,
    input  logic             push1_i,
    input  logic [31:0]      push1_addr_i,
    input  logic [31:0]      push1_data_i,
    input  logic             pop_i,
    input  logic [31:0]      match3_addr_i,
    input  logic [31:0]      match4_addr_i,
    output logic [31:0]      head_addr_o,
    output logic [31:0]      head_data_o,
    output logic [PTR_W:0]   count_o,
    output logic             empty_o,
    output logic             match3_o,
    output logic             match4_o
);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d, wr1;
    logic [PTR_W:0]   cnt_q, cnt_d;

    // Port 1 lands behind port 0 when both push in the same cycle.
    assign wr1   = wr_q + PTR_W'(push0_i);
    assign rd_d  = rd_q + PTR_W'(pop_i);
    assign wr_d  = wr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    assign cnt_d = cnt_q + (PTR_W+1)'(push0_i) + (PTR_W+1)'(push1_i)
                 - (PTR_W+1)'(pop_i);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push0_i) begin
            addr_q[wr_q] <= push0_addr_i;
            data_q[wr_q] <= push0_data_i;
        end
        if (push1_i) begin
            addr_q[wr1] <= push1_addr_i;
            data_q[wr1] <= push1_data_i;
        end
    end

    always_comb begin
        match3_o = 1'b0;
        match4_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((PTR_W+1)'(i) < cnt_q) begin
                if (addr_q[rd_q + PTR_W'(i)] == match3_addr_i) match3_o = 1'b1;
                if (addr_q[rd_q + PTR_W'(i)] == match4_addr_i) match4_o = 1'b1;
            end
        end
    end

    assign head_addr_o = addr_q[rd_q];
    assign head_data_o = data_q[rd_q];
    assign count_o     = cnt_q;
    assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/dmem_lane_sched.sv
// Arbitrates one single-port data memory between VLIW lanes 3 and 4:
// loads take the port first, posted stores drain from a queue when idle.
module dmem_lane_sched
    import dmem_lane_sched_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        v3,
    input  logic        we3,
    input  logic [31:0] addr3,
    input  logic [31:0] wdata3,
    input  logic        v4,
    input  logic        we4,
    input  logic [31:0] addr4,
    input  logic [31:0] wdata4,
    output logic        stall,
    output logic [31:0] rdata3,
    output logic [31:0] rdata4,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        sq_empty
);

    state_e         state_q, state_d;
    logic [31:0]    hold3_q;
    logic           prev_ld4_q;
    logic           st3_done_q, st3_done_d;

    logic           ld3, st3, ld4, st4, eff_st3, inb;
    logic           hz3, hz4, full, blocked, two_ld;
    logic [PTR_W:0] count, nst, room;
    logic           q_empty, m3, m4;
    logic [31:0]    head_addr, head_data;
    logic           pop, push0, push1, drain, rd_en;
    logic [31:0]    rd_addr;

    assign ld3 = v3 & ~we3;
    assign st3 = v3 & we3;
    assign ld4 = v4 & ~we4;
    assign st4 = v4 & we4;

    // A lane-3 store feeding a lane-4 load of the same address would never
    // reach the queue while the bundle stalls, so it is queued early once and
    // then ignored until the bundle is finally accepted.
    assign eff_st3 = st3 & ~st3_done_q;
    assign inb     = eff_st3 & ld4 & (addr3 == addr4);
    assign hz3     = ld3 & m3;
    assign hz4     = ld4 & (m4 | inb);
    assign nst     = (PTR_W+1)'(eff_st3) + (PTR_W+1)'(st4);
    assign room    = (PTR_W+1)'(DEPTH) - count;
    assign full    = nst > room;
    assign blocked = hz3 | hz4 | full;
    assign two_ld  = ld3 & ld4;

    store_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_sq (
        .clk          (clk),
        .rstn         (rstn),
        .push0_i      (push0),
        .push0_addr_i (addr3),
        .push0_data_i (wdata3),
        .push1_i      (push1),
        .push1_addr_i (addr4),
        .push1_data_i (wdata4),
        .pop_i        (pop),
        .match3_addr_i(addr3),
        .match4_addr_i(addr4),
        .head_addr_o  (head_addr),
        .head_data_o  (head_data),
        .count_o      (count),
        .empty_o      (q_empty),
        .match3_o     (m3),
        .match4_o     (m4)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_RUN;
            hold3_q    <= '0;
            prev_ld4_q <= 1'b0;
            st3_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_ld4_q <= (state_q == S_LOAD4);
            st3_done_q <= st3_done_d;
            if (state_q == S_LOAD4) hold3_q <= mem_rdata;
        end
    end

    always_comb begin
        state_d    = state_q;
        st3_done_d = st3_done_q;
        case (state_q)
            S_RUN: begin
                if (blocked) begin
                    if (inb && !full) st3_done_d = 1'b1;
                end else if (two_ld) begin
                    state_d = S_LOAD4;
                end else begin
                    st3_done_d = 1'b0;
                end
            end
            S_LOAD4: state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_comb begin
        stall   = 1'b0;
        drain   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = '0;
        push0   = 1'b0;
        push1   = 1'b0;
        if (rstn) begin
            case (state_q)
                S_LOAD4: begin
                    rd_en   = 1'b1;
                    rd_addr = addr4;
                end
                S_RUN: begin
                    if (blocked) begin
                        stall = 1'b1;
                        drain = ~q_empty;
                        push0 = inb & ~full;
                    end else if (two_ld) begin
                        stall   = 1'b1;
                        rd_en   = 1'b1;
                        rd_addr = addr3;
                    end else begin
                        push0 = eff_st3;
                        push1 = st4;
                        if (ld3) begin
                            rd_en   = 1'b1;
                            rd_addr = addr3;
                        end else if (ld4) begin
                            rd_en   = 1'b1;
                            rd_addr = addr4;
                        end else begin
                            drain = ~q_empty;
                        end
                    end
                end
                default: ;
            endcase
        end
        pop       = drain;
        mem_en    = rd_en | drain;
        mem_we    = drain;
        mem_addr  = drain ? head_addr : rd_addr;
        mem_wdata = drain ? head_data : '0;
    end

    assign sq_empty = ~rstn | q_empty;
    assign rdata3   = prev_ld4_q ? hold3_q : mem_rdata;
    assign rdata4   = mem_rdata;

endmodule

// File: tb/tb_dmem_lane_sched.sv
// Bench for dmem_lane_sched: queue-based reference model plus a program-order
// memory image, directed scenarios and randomized bundles.
module tb_dmem_lane_sched;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        v3, we3, v4, we4;
    logic [31:0] addr3, wdata3, addr4, wdata4;
    logic        stall, mem_en, mem_we, sq_empty;
    logic [31:0] rdata3, rdata4, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    dmem_lane_sched #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .v3       (v3),
        .we3      (we3),
        .addr3    (addr3),
        .wdata3   (wdata3),
        .v4       (v4),
        .we4      (we4),
        .addr4    (addr4),
        .wdata4   (wdata4),
        .stall    (stall),
        .rdata3   (rdata3),
        .rdata4   (rdata4),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .sq_empty (sq_empty)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_cnt = 0;

    logic [31:0] smem [logic [31:0]];
    logic [31:0] arch [logic [31:0]];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } ent_t;
    ent_t mq [$];

    bit          m_ld4 = 0, m_st3done = 0;
    bit          chk3 = 0, chk4 = 0;
    logic [31:0] e3, e4;

    function automatic void cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void cmpb(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        return arch.exists(a) ? arch[a] : 32'h0;
    endfunction

    function automatic logic [31:0] smem_rd(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : 32'h0;
    endfunction

    // Single-port memory with one cycle of read latency.
    initial begin : memory
        forever begin
            @(posedge clk);
            if (mem_en && !mem_we) mem_rdata <= smem_rd(mem_addr);
            if (mem_en && mem_we) begin
                smem[mem_addr] = mem_wdata;
                wr_cnt++;
            end
        end
    end

    // Reference model: pending stores as a plain queue, loads checked against
    // a memory image updated in program order at bundle acceptance.
    initial begin : model
        bit          l3, s3, l4, s4, es3, h3, h4, inb, full;
        bit          drain, rd, acc, p3, p4, two;
        logic [31:0] raddr;
        int          nst;
        forever begin
            @(negedge clk);
            if (chk3) cmp("rdata3", rdata3, e3);
            if (chk4) cmp("rdata4", rdata4, e4);
            chk3 = 0;
            chk4 = 0;
            if (!rstn) begin
                cmpb("rst_stall", stall, 1'b0);
                cmpb("rst_mem_en", mem_en, 1'b0);
                cmpb("rst_mem_we", mem_we, 1'b0);
                cmpb("rst_sq_empty", sq_empty, 1'b1);
                mq.delete();
                m_ld4     = 0;
                m_st3done = 0;
                arch      = smem;
            end else begin
                l3  = v3 && !we3;
                s3  = v3 && we3;
                l4  = v4 && !we4;
                s4  = v4 && we4;
                es3 = s3 && !m_st3done;
                h3  = 0;
                h4  = 0;
                foreach (mq[i]) begin
                    if (mq[i].a == addr3) h3 = 1;
                    if (mq[i].a == addr4) h4 = 1;
                end
                inb   = es3 && l4 && (addr3 == addr4);
                nst   = int'(es3) + int'(s4);
                full  = nst > (DEPTH - mq.size());
                drain = 0; rd = 0; acc = 0; p3 = 0; p4 = 0; two = 0; raddr = '0;
                if (m_ld4) begin
                    rd = 1; raddr = addr4; acc = 1;
                end else if ((l3 && h3) || (l4 && (h4 || inb)) || full) begin
                    drain = (mq.size() > 0);
                    p3    = inb && !full;
                end else if (l3 && l4) begin
                    rd = 1; raddr = addr3; two = 1;
                end else begin
                    acc = 1;
                    if (l3) begin rd = 1; raddr = addr3; end
                    else if (l4) begin rd = 1; raddr = addr4; end
                    else drain = (mq.size() > 0);
                    p3 = es3;
                    p4 = s4;
                end
                cmpb("stall", stall, !acc);
                cmpb("sq_empty", sq_empty, mq.size() == 0);
                cmpb("mem_en", mem_en, rd || drain);
                cmpb("mem_we", mem_we, drain);
                if (rd) cmp("mem_raddr", mem_addr, raddr);
                if (drain) begin
                    cmp("mem_waddr", mem_addr, mq[0].a);
                    cmp("mem_wdata", mem_wdata, mq[0].d);
                end
                if (acc) begin
                    if (l3) begin e3 = arch_rd(addr3); chk3 = 1; end
                    if (s3) arch[addr3] = wdata3;
                    if (l4) begin e4 = arch_rd(addr4); chk4 = 1; end
                    if (s4) arch[addr4] = wdata4;
                end
                if (drain) void'(mq.pop_front());
                if (p3) mq.push_back({addr3, wdata3});
                if (p4) mq.push_back({addr4, wdata4});
                m_ld4 = two;
                if (acc) m_st3done = 0;
                else if (p3) m_st3done = 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        v3 = 0; we3 = 0; addr3 = '0; wdata3 = '0;
        v4 = 0; we4 = 0; addr4 = '0; wdata4 = '0;
    endtask

    // Hold a bundle until accepted; returns one time unit after the accepting edge.
    task automatic present(input logic iv3, input logic iwe3, input logic [31:0] ia3,
                           input logic [31:0] id3, input logic iv4, input logic iwe4,
                           input logic [31:0] ia4, input logic [31:0] id4, output int ns);
        bit ok;
        v3 = iv3; we3 = iwe3; addr3 = ia3; wdata3 = id3;
        v4 = iv4; we4 = iwe4; addr4 = ia4; wdata4 = id4;
        ns = 0;
        ok = 0;
        while (!ok && ns < 200) begin
            @(negedge clk);
            if (!stall) ok = 1;
            else ns++;
        end
        cmpb("accept_in_time", ok, 1'b1);
        step();
    endtask

    task automatic wait_empty();
        int k = 0;
        while (!sq_empty && k < 100) begin
            step();
            k++;
        end
        cmpb("drain_in_time", sq_empty, 1'b1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin : stim
        int ns;
        int saved;
        bit acc_prev;
        rstn = 0;
        idle();
        smem[32'h20] = 32'd5;
        smem[32'h24] = 32'd7;
        @(negedge clk);
        cmpb("reset_stall", stall, 1'b0);
        cmpb("reset_mem_en", mem_en, 1'b0);
        cmpb("reset_sq_empty", sq_empty, 1'b1);
        step();
        step();
        rstn = 1;

        present(1, 0, 32'h20, 0, 1, 0, 32'h24, 0, ns);
        cmp("two_load_stalls", ns, 1);
        idle();
        @(negedge clk);
        cmp("two_load_rd3", rdata3, 32'd5);
        cmp("two_load_rd4", rdata4, 32'd7);
        step();

        present(1, 1, 32'h10, 32'hAA, 1, 1, 32'h14, 32'hBB, ns);
        cmp("two_store_stalls", ns, 0);
        idle();
        @(negedge clk);
        cmpb("st_first_we", mem_we, 1'b1);
        cmp("st_first_addr", mem_addr, 32'h10);
        cmp("st_first_data", mem_wdata, 32'hAA);
        step();
        @(negedge clk);
        cmp("st_second_addr", mem_addr, 32'h14);
        cmp("st_second_data", mem_wdata, 32'hBB);
        step();
        cmpb("st_empty_after", sq_empty, 1'b1);

        present(1, 1, 32'h34, 32'd1, 1, 1, 32'h30, 32'd9, ns);
        present(1, 0, 32'h30, 0, 0, 0, 0, 0, ns);
        cmp("raw_stalls", ns, 2);
        idle();
        @(negedge clk);
        cmp("raw_rd3", rdata3, 32'd9);
        step();

        wait_empty();
        present(1, 1, 32'h40, 32'd3, 1, 0, 32'h40, 0, ns);
        cmp("inb_stalls", ns, 2);
        idle();
        @(negedge clk);
        cmp("inb_rd4", rdata4, 32'd3);
        step();
        wait_empty();
        present(1, 0, 32'h40, 0, 1, 1, 32'h40, 32'h55, ns);
        cmp("war_stalls", ns, 0);
        idle();
        @(negedge clk);
        cmp("war_rd3_old", rdata3, 32'd3);
        step();

        wait_empty();
        for (int i = 0; i < 8; i++)
            present(1, 0, 32'h200, 0, 1, 1, 32'h300 + 32'(4 * i), 32'(i + 1), ns);
        present(1, 1, 32'h400, 32'hA0, 1, 1, 32'h404, 32'hA1, ns);
        cmp("full_stalls", ns, 2);
        idle();
        wait_empty();
        for (int i = 0; i < 8; i++)
            cmp("full_mem", smem_rd(32'h300 + 32'(4 * i)), 32'(i + 1));
        cmp("full_mem_400", smem_rd(32'h400), 32'hA0);
        cmp("full_mem_404", smem_rd(32'h404), 32'hA1);

        for (int i = 0; i < 4; i++)
            present(1, 1, 32'h500 + 32'(8 * i), 32'(i), 1, 1, 32'h504 + 32'(8 * i), 32'(i + 16), ns);
        rstn = 0;
        idle();
        @(negedge clk);
        cmpb("midrst_sq_empty", sq_empty, 1'b1);
        cmpb("midrst_mem_we", mem_we, 1'b0);
        saved = wr_cnt;
        step();
        rstn = 1;
        repeat (20) step();
        cmp("midrst_no_writes", wr_cnt, saved);
        cmpb("midrst_still_empty", sq_empty, 1'b1);

        acc_prev = 1;
        for (int c = 0; c < 1500; c++) begin
            if (acc_prev) begin
                v3     = ($urandom_range(0, 3) != 0);
                we3    = 1'($urandom_range(0, 1));
                addr3  = 32'h80 + 32'(4 * $urandom_range(0, 5));
                wdata3 = $urandom;
                v4     = ($urandom_range(0, 3) != 0);
                we4    = 1'($urandom_range(0, 1));
                addr4  = 32'h80 + 32'(4 * $urandom_range(0, 5));
                wdata4 = $urandom;
            end
            @(negedge clk);
            acc_prev = !stall;
            step();
        end
        idle();
        wait_empty();
        step();
        for (int i = 0; i < 6; i++)
            cmp("rand_final_mem", smem_rd(32'h80 + 32'(4 * i)), arch_rd(32'h80 + 32'(4 * i)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
